// File: rtl/mem_lane_arbiter_if.sv
// mem_lane_arbiter_if
// Request/handshake bundle between the lane arbiter and the data cache.
// One transaction may be outstanding at a time: the request phase completes
// on data_addr_ok, and the data phase completes on data_data_ok.
//
// Signals:
//   data_req      arbiter -> cache, request valid
//   data_wr       arbiter -> cache, 1 = store, 0 = load
//   data_op       arbiter -> cache, memory op code of the requesting lane
//   data_addr     arbiter -> cache, byte address
//   data_wdata    arbiter -> cache, store data
//   data_addr_ok  cache -> arbiter, request accepted
//   data_data_ok  cache -> arbiter, data phase complete
//   data_rdata    cache -> arbiter, load data (valid with data_data_ok)
//
// Modports:
//   master  the arbiter side
//   slave   the cache side
interface mem_lane_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          data_req;
  logic          data_wr;
  logic [5:0]    data_op;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_addr_ok;
  logic          data_data_ok;
  logic [DW-1:0] data_rdata;

  modport master (
    output data_req, data_wr, data_op, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_op, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_lane_arbiter.sv
// mem_lane_arbiter
// Serialises the memory ops of a multi-issue bundle, oldest lane first,
// onto a single data-cache port. Load data is buffered per lane until the
// pipeline accepts the bundle, and the pipeline is stalled while any access
// of the bundle is still in flight. Alignment faults and exception precedence
// across lanes are resolved here: a faulting lane kills itself and every
// younger lane.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   flush         discard the current bundle
//   advance       pipeline accepts the bundle this cycle
//   lane_en       lane carries a memory op
//   lane_ren      lane op is a load
//   lane_wen      lane op is a store
//   lane_exp      lane already carries an exception (non-alignment)
//   lane_op       6-bit op code per lane, packed lane 0 in the LSBs
//   lane_addr     AW-bit address per lane, packed
//   lane_wdata    DW-bit store data per lane, packed
//   lane_adel     load misalignment per lane (combinational)
//   lane_ades     store misalignment per lane (combinational)
//   lane_sel      lane will perform its access (combinational)
//   lane_rdata    buffered load data per lane, packed (registered)
//   lane_rvalid   buffered load data valid per lane (registered)
//   stall         hold the pipeline
//   dcache        data-cache request/response port (master side)
module mem_lane_arbiter #(
  parameter int LANES = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  advance,
  input  logic [LANES-1:0]      lane_en,
  input  logic [LANES-1:0]      lane_ren,
  input  logic [LANES-1:0]      lane_wen,
  input  logic [LANES-1:0]      lane_exp,
  input  logic [6*LANES-1:0]    lane_op,
  input  logic [AW*LANES-1:0]   lane_addr,
  input  logic [DW*LANES-1:0]   lane_wdata,
  output logic [LANES-1:0]      lane_adel,
  output logic [LANES-1:0]      lane_ades,
  output logic [LANES-1:0]      lane_sel,
  output logic [DW*LANES-1:0]   lane_rdata,
  output logic [LANES-1:0]      lane_rvalid,
  output logic                  stall,
  mem_lane_arbiter_if.master    dcache
);

  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DONE,
    DRAIN
  } state_t;

  state_t          state, state_next;
  logic [LANES-1:0] pend, pend_next;
  logic [LANES-1:0] rvalid_q, rvalid_next;
  logic [LANES-1:0] rbuf_we;
  logic [LANES-1:0] cur_bit;
  logic [IW-1:0]    cur_lane;
  logic [DW-1:0]    rbuf [LANES];

  // Alignment checks and lane selection. The running no-fault flag walks
  // from the oldest lane upward so that a fault in any older lane (or in the
  // lane itself) suppresses the access.
  always_comb begin
    logic [5:0] op_i;
    logic [1:0] addr_lo;
    logic       no_fault_yet;
    logic [LANES-1:0] fault;
    lane_adel    = '0;
    lane_ades    = '0;
    lane_sel     = '0;
    fault        = '0;
    op_i         = '0;
    addr_lo      = '0;
    no_fault_yet = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      op_i    = lane_op[6*i +: 6];
      addr_lo = lane_addr[AW*i +: 2];
      lane_adel[i] = ((op_i == OP_LW) && (addr_lo != 2'b00)) ||
                     (((op_i == OP_LH) || (op_i == OP_LHU)) && addr_lo[0]);
      lane_ades[i] = ((op_i == OP_SW) && (addr_lo != 2'b00)) ||
                     ((op_i == OP_SH) && addr_lo[0]);
      fault[i]     = lane_exp[i] | lane_adel[i] | lane_ades[i];
      no_fault_yet = no_fault_yet & ~fault[i];
      lane_sel[i]  = lane_en[i] & no_fault_yet;
    end
  end

  // The lane being served is always the oldest one still pending. Both the
  // index (for muxing lane data) and the one-hot form (for clearing and
  // buffer writes) are derived from the pending mask.
  always_comb begin
    cur_lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (pend[i]) cur_lane = IW'(i);
    end
    cur_bit = pend & (~pend + LANES'(1));
  end

  // State, pending mask and load-valid flags. Reset drops straight back to
  // IDLE without waiting for a clock, which also pulls data_req low at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pend     <= '0;
      rvalid_q <= '0;
    end else begin
      state    <= state_next;
      pend     <= pend_next;
      rvalid_q <= rvalid_next;
    end
  end

  // Per-lane load buffers. Written only when a load's data phase completes
  // in WAIT; they keep their contents across bundles, with lane_rvalid
  // telling the pipeline which of them belong to the current bundle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) rbuf[i] <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (rbuf_we[i]) rbuf[i] <= dcache.data_rdata;
      end
    end
  end

  // Next-state logic. A flush anywhere in the bundle clears the pending mask
  // and the valid flags; if the cache has already accepted the request the
  // data phase still has to be absorbed, which is what DRAIN is for.
  always_comb begin
    state_next  = state;
    pend_next   = pend;
    rvalid_next = rvalid_q;
    rbuf_we     = '0;
    case (state)
      IDLE: begin
        if ((|lane_sel) && !flush) begin
          pend_next   = lane_sel;
          rvalid_next = '0;
          state_next  = REQ;
        end
      end
      REQ: begin
        if (flush) begin
          pend_next   = '0;
          rvalid_next = '0;
          state_next  = dcache.data_addr_ok ? DRAIN : IDLE;
        end else if (dcache.data_addr_ok) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          pend_next   = '0;
          rvalid_next = '0;
          state_next  = dcache.data_data_ok ? IDLE : DRAIN;
        end else if (dcache.data_data_ok) begin
          if (lane_ren[cur_lane]) begin
            rbuf_we     = cur_bit;
            rvalid_next = rvalid_q | cur_bit;
          end
          pend_next  = pend & ~cur_bit;
          state_next = (|(pend & ~cur_bit)) ? REQ : DONE;
        end
      end
      DONE: begin
        if (advance || flush) begin
          rvalid_next = '0;
          state_next  = IDLE;
        end
      end
      DRAIN: begin
        if (dcache.data_data_ok) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Cache request outputs are driven only in REQ, with every field taken
  // from the oldest pending lane; all fields read zero elsewhere.
  always_comb begin
    dcache.data_req   = 1'b0;
    dcache.data_wr    = 1'b0;
    dcache.data_op    = '0;
    dcache.data_addr  = '0;
    dcache.data_wdata = '0;
    if (state == REQ) begin
      dcache.data_req   = 1'b1;
      dcache.data_wr    = lane_wen[cur_lane];
      dcache.data_op    = lane_op[6*cur_lane +: 6];
      dcache.data_addr  = lane_addr[AW*cur_lane +: AW];
      dcache.data_wdata = lane_wdata[DW*cur_lane +: DW];
    end
  end

  // Stall is raised in the same cycle a bundle with work arrives, so the
  // pipeline never moves past a bundle that has not started its accesses.
  always_comb begin
    stall = !rst && (((state == IDLE) && (|lane_sel) && !flush) ||
                     (state == REQ) || (state == WAIT) || (state == DRAIN));
  end

  // Expose the load buffers as the packed read-data bus.
  always_comb begin
    lane_rdata = '0;
    for (int i = 0; i < LANES; i++) lane_rdata[DW*i +: DW] = rbuf[i];
    lane_rvalid = rvalid_q;
  end

endmodule

// File: tb/tb_mem_lane_arbiter.sv
// tb_mem_lane_arbiter
// Directed bench for mem_lane_arbiter with two lanes. Each task drives one
// scenario cycle by cycle and compares outputs against hand-computed values.
module tb_mem_lane_arbiter;

  localparam logic [5:0] OP_LH = 6'h21;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;

  logic        clk, rst, flush, advance;
  logic [1:0]  lane_en, lane_ren, lane_wen, lane_exp;
  logic [11:0] lane_op;
  logic [63:0] lane_addr, lane_wdata;
  logic [1:0]  lane_adel, lane_ades, lane_sel, lane_rvalid;
  logic [63:0] lane_rdata;
  logic        stall;

  int tests = 0;
  int failures = 0;

  mem_lane_arbiter_if #(.AW(32), .DW(32)) dc_if ();

  mem_lane_arbiter #(.LANES(2), .AW(32), .DW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .advance    (advance),
    .lane_en    (lane_en),
    .lane_ren   (lane_ren),
    .lane_wen   (lane_wen),
    .lane_exp   (lane_exp),
    .lane_op    (lane_op),
    .lane_addr  (lane_addr),
    .lane_wdata (lane_wdata),
    .lane_adel  (lane_adel),
    .lane_ades  (lane_ades),
    .lane_sel   (lane_sel),
    .lane_rdata (lane_rdata),
    .lane_rvalid(lane_rvalid),
    .stall      (stall),
    .dcache     (dc_if)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic en, input logic ren,
                          input logic wen, input logic exp,
                          input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata);
    lane_en[i]           = en;
    lane_ren[i]          = ren;
    lane_wen[i]          = wen;
    lane_exp[i]          = exp;
    lane_op[6*i +: 6]    = op;
    lane_addr[32*i +: 32] = addr;
    lane_wdata[32*i +: 32] = wdata;
  endtask

  task automatic clear_lanes();
    lane_en = '0; lane_ren = '0; lane_wen = '0; lane_exp = '0;
    lane_op = '0; lane_addr = '0; lane_wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; advance = 1'b0;
    clear_lanes();
    dc_if.data_addr_ok = 1'b0; dc_if.data_data_ok = 1'b0; dc_if.data_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall: got %b want 0", stall); end
    tests++; if (dc_if.data_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_req: got %b want 0", dc_if.data_req); end
    tests++; if (lane_rvalid !== 2'b00) begin failures++; $display("[TB] FAIL reset_rvalid: got %b want 00", lane_rvalid); end
    tests++; if (lane_rdata !== 64'h0) begin failures++; $display("[TB] FAIL reset_rdata: got %h want 0", lane_rdata); end
    rst = 1'b0;
  endtask

  task automatic test_single_lw();
    set_lane(0, 1, 1, 0, 0, OP_LW, 32'h100, 32'h0);
    #1;
    tests++; if (stall !== 1'b1) begin failures++; $display("[TB] FAIL single_T_stall: got %b want 1", stall); end
    tests++; if (lane_sel !== 2'b01) begin failures++; $display("[TB] FAIL single_T_sel: got %b want 01", lane_sel); end
    tests++; if (dc_if.data_req !== 1'b0) begin failures++; $display("[TB] FAIL single_T_req: got %b want 0", dc_if.data_req); end
    step();
    tests++; if (dc_if.data_req !== 1'b1) begin failures++; $display("[TB] FAIL single_T1_req: got %b want 1", dc_if.data_req); end
    tests++; if (dc_if.data_addr !== 32'h100) begin failures++; $display("[TB] FAIL single_T1_addr: got %h want 100", dc_if.data_addr); end
    tests++; if (dc_if.data_op !== OP_LW) begin failures++; $display("[TB] FAIL single_T1_op: got %h want %h", dc_if.data_op, OP_LW); end
    tests++; if (dc_if.data_wr !== 1'b0) begin failures++; $display("[TB] FAIL single_T1_wr: got %b want 0", dc_if.data_wr); end
    dc_if.data_addr_ok = 1'b1;
    step();
    dc_if.data_addr_ok = 1'b0;
    tests++; if (dc_if.data_req !== 1'b0) begin failures++; $display("[TB] FAIL single_T2_req: got %b want 0", dc_if.data_req); end
    tests++; if (stall !== 1'b1) begin failures++; $display("[TB] FAIL single_T2_stall: got %b want 1", stall); end
    dc_if.data_data_ok = 1'b1; dc_if.data_rdata = 32'hDEADBEEF;
    step();
    dc_if.data_data_ok = 1'b0; dc_if.data_rdata = '0;
    tests++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL single_T3_stall: got %b want 0", stall); end
    tests++; if (lane_rvalid !== 2'b01) begin failures++; $display("[TB] FAIL single_T3_rvalid: got %b want 01", lane_rvalid); end
    tests++; if (lane_rdata[31:0] !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL single_T3_rdata: got %h want deadbeef", lane_rdata[31:0]); end
    advance = 1'b1;
    step();
    advance = 1'b0; clear_lanes();
    tests++; if (lane_rvalid !== 2'b00) begin failures++; $display("[TB] FAIL single_after_adv_rvalid: got %b want 00", lane_rvalid); end
  endtask

  task automatic test_two_lanes();
    set_lane(0, 1, 1, 0, 0, OP_LW, 32'h200, 32'h0);
    set_lane(1, 1, 0, 1, 0, OP_SW, 32'h204, 32'h12345678);
    #1;
    tests++; if (lane_sel !== 2'b11) begin failures++; $display("[TB] FAIL two_T_sel: got %b want 11", lane_sel); end
    step();
    tests++; if (dc_if.data_addr !== 32'h200) begin failures++; $display("[TB] FAIL two_T1_addr: got %h want 200", dc_if.data_addr); end
    dc_if.data_addr_ok = 1'b1;
    step();
    dc_if.data_addr_ok = 1'b0;
    dc_if.data_data_ok = 1'b1; dc_if.data_rdata = 32'hCAFEF00D;
    step();
    dc_if.data_data_ok = 1'b0; dc_if.data_rdata = '0;
    tests++; if (dc_if.data_req !== 1'b1) begin failures++; $display("[TB] FAIL two_T3_req: got %b want 1", dc_if.data_req); end
    tests++; if (dc_if.data_addr !== 32'h204) begin failures++; $display("[TB] FAIL two_T3_addr: got %h want 204", dc_if.data_addr); end
    tests++; if (dc_if.data_wr !== 1'b1) begin failures++; $display("[TB] FAIL two_T3_wr: got %b want 1", dc_if.data_wr); end
    tests++; if (dc_if.data_wdata !== 32'h12345678) begin failures++; $display("[TB] FAIL two_T3_wdata: got %h want 12345678", dc_if.data_wdata); end
    tests++; if (stall !== 1'b1) begin failures++; $display("[TB] FAIL two_T3_stall: got %b want 1", stall); end
    dc_if.data_addr_ok = 1'b1;
    step();
    dc_if.data_addr_ok = 1'b0;
    tests++; if (stall !== 1'b1) begin failures++; $display("[TB] FAIL two_T4_stall: got %b want 1", stall); end
    dc_if.data_data_ok = 1'b1; dc_if.data_rdata = 32'h55555555;
    step();
    dc_if.data_data_ok = 1'b0; dc_if.data_rdata = '0;
    tests++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL two_T5_stall: got %b want 0", stall); end
    tests++; if (lane_rvalid !== 2'b01) begin failures++; $display("[TB] FAIL two_T5_rvalid: got %b want 01", lane_rvalid); end
    tests++; if (lane_rdata !== 64'h00000000_CAFEF00D) begin failures++; $display("[TB] FAIL two_T5_rdata: got %h want 00000000cafef00d", lane_rdata); end
    advance = 1'b1;
    step();
    advance = 1'b0; clear_lanes();
  endtask

  task automatic test_alignment();
    set_lane(0, 1, 1, 0, 0, OP_LH, 32'h301, 32'h0);
    #1;
    tests++; if (lane_adel !== 2'b01) begin failures++; $display("[TB] FAIL lh_adel: got %b want 01", lane_adel); end
    tests++; if (lane_sel !== 2'b00) begin failures++; $display("[TB] FAIL lh_sel: got %b want 00", lane_sel); end
    tests++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL lh_stall: got %b want 0", stall); end
    step();
    tests++; if (dc_if.data_req !== 1'b0) begin failures++; $display("[TB] FAIL lh_req: got %b want 0", dc_if.data_req); end
    set_lane(0, 1, 0, 1, 0, OP_SW, 32'h102, 32'h0);
    #1;
    tests++; if (lane_ades !== 2'b01) begin failures++; $display("[TB] FAIL sw_ades: got %b want 01", lane_ades); end
    set_lane(0, 1, 1, 0, 1, OP_LW, 32'h000, 32'h0);
    set_lane(1, 1, 1, 0, 0, OP_LW, 32'h008, 32'h0);
    #1;
    tests++; if (lane_sel !== 2'b00) begin failures++; $display("[TB] FAIL exp_sel: got %b want 00", lane_sel); end
    tests++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL exp_stall: got %b want 0", stall); end
    step();
    set_lane(0, 1, 1, 0, 0, OP_LW, 32'h400, 32'h0);
    set_lane(1, 1, 1, 0, 0, OP_LW, 32'h402, 32'h0);
    #1;
    tests++; if (lane_adel !== 2'b10) begin failures++; $display("[TB] FAIL young_adel: got %b want 10", lane_adel); end
    tests++; if (lane_sel !== 2'b01) begin failures++; $display("[TB] FAIL young_sel: got %b want 01", lane_sel); end
    step();
    tests++; if (dc_if.data_addr !== 32'h400) begin failures++; $display("[TB] FAIL young_addr: got %h want 400", dc_if.data_addr); end
    dc_if.data_addr_ok = 1'b1;
    step();
    dc_if.data_addr_ok = 1'b0;
    dc_if.data_data_ok = 1'b1; dc_if.data_rdata = 32'h11112222;
    step();
    dc_if.data_data_ok = 1'b0; dc_if.data_rdata = '0;
    tests++; if (dc_if.data_req !== 1'b0) begin failures++; $display("[TB] FAIL young_T3_req: got %b want 0", dc_if.data_req); end
    tests++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL young_T3_stall: got %b want 0", stall); end
    tests++; if (lane_rvalid !== 2'b01) begin failures++; $display("[TB] FAIL young_T3_rvalid: got %b want 01", lane_rvalid); end
    advance = 1'b1;
    step();
    advance = 1'b0; clear_lanes();
  endtask

  task automatic test_flush();
    // Flush while WAIT: drain the outstanding data phase.
    set_lane(0, 1, 1, 0, 0, OP_LW, 32'h500, 32'h0);
    step();
    dc_if.data_addr_ok = 1'b1;
    step();
    dc_if.data_addr_ok = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0; clear_lanes();
    tests++; if (stall !== 1'b1) begin failures++; $display("[TB] FAIL drain_stall0: got %b want 1", stall); end
    tests++; if (dc_if.data_req !== 1'b0) begin failures++; $display("[TB] FAIL drain_req: got %b want 0", dc_if.data_req); end
    step();
    tests++; if (stall !== 1'b1) begin failures++; $display("[TB] FAIL drain_stall1: got %b want 1", stall); end
    dc_if.data_data_ok = 1'b1; dc_if.data_rdata = 32'h99999999;
    step();
    dc_if.data_data_ok = 1'b0; dc_if.data_rdata = '0;
    tests++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL drain_exit_stall: got %b want 0", stall); end
    tests++; if (lane_rvalid !== 2'b00) begin failures++; $display("[TB] FAIL drain_exit_rvalid: got %b want 00", lane_rvalid); end
    // Flush in REQ before addr_ok: request withdrawn the next cycle.
    set_lane(0, 1, 1, 0, 0, OP_LW, 32'h600, 32'h0);
    step();
    tests++; if (dc_if.data_req !== 1'b1) begin failures++; $display("[TB] FAIL reqflush_req_before: got %b want 1", dc_if.data_req); end
    flush = 1'b1;
    step();
    flush = 1'b0; clear_lanes();
    tests++; if (dc_if.data_req !== 1'b0) begin failures++; $display("[TB] FAIL reqflush_req_after: got %b want 0", dc_if.data_req); end
    tests++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL reqflush_stall: got %b want 0", stall); end
  endtask

  task automatic test_done_hold();
    set_lane(0, 1, 1, 0, 0, OP_LW, 32'h700, 32'h0);
    step();
    dc_if.data_addr_ok = 1'b1;
    step();
    dc_if.data_addr_ok = 1'b0;
    dc_if.data_data_ok = 1'b1; dc_if.data_rdata = 32'hA5A5A5A5;
    step();
    dc_if.data_data_ok = 1'b0; dc_if.data_rdata = '0;
    for (int c = 0; c < 3; c++) begin
      tests++; if (dc_if.data_req !== 1'b0) begin failures++; $display("[TB] FAIL hold%0d_req: got %b want 0", c, dc_if.data_req); end
      tests++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL hold%0d_stall: got %b want 0", c, stall); end
      tests++; if (lane_rdata[31:0] !== 32'hA5A5A5A5) begin failures++; $display("[TB] FAIL hold%0d_rdata: got %h want a5a5a5a5", c, lane_rdata[31:0]); end
      tests++; if (lane_rvalid !== 2'b01) begin failures++; $display("[TB] FAIL hold%0d_rvalid: got %b want 01", c, lane_rvalid); end
      step();
    end
    advance = 1'b1;
    step();
    advance = 1'b0; clear_lanes();
  endtask

  task automatic test_reset_mid();
    // Reset while REQ: data_req must drop without a clock edge.
    set_lane(0, 1, 1, 0, 0, OP_LW, 32'h800, 32'h0);
    step();
    tests++; if (dc_if.data_req !== 1'b1) begin failures++; $display("[TB] FAIL rstreq_req_before: got %b want 1", dc_if.data_req); end
    #1 rst = 1'b1;
    #1;
    tests++; if (dc_if.data_req !== 1'b0) begin failures++; $display("[TB] FAIL rstreq_req_after: got %b want 0", dc_if.data_req); end
    step();
    rst = 1'b0;
    // Reset while WAIT: every output returns to its reset value.
    step();
    dc_if.data_addr_ok = 1'b1;
    step();
    dc_if.data_addr_ok = 1'b0;
    tests++; if (stall !== 1'b1) begin failures++; $display("[TB] FAIL rstwait_stall_before: got %b want 1", stall); end
    #1 rst = 1'b1;
    #1;
    tests++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL rstwait_stall: got %b want 0", stall); end
    tests++; if (dc_if.data_req !== 1'b0) begin failures++; $display("[TB] FAIL rstwait_req: got %b want 0", dc_if.data_req); end
    tests++; if (lane_rvalid !== 2'b00) begin failures++; $display("[TB] FAIL rstwait_rvalid: got %b want 00", lane_rvalid); end
    tests++; if (lane_rdata !== 64'h0) begin failures++; $display("[TB] FAIL rstwait_rdata: got %h want 0", lane_rdata); end
    clear_lanes();
    step();
    rst = 1'b0;
    step();
    tests++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL rstwait_idle_stall: got %b want 0", stall); end
  endtask

  initial begin
    test_reset();
    test_single_lw();
    test_two_lanes();
    test_alignment();
    test_flush();
    test_done_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
